// File: rtl/poly_mod_sub_if.sv
// Handshake bundle for poly_mod_sub: coefficient-pair input stream plus
// result stream with per-polynomial index, end marker and sticky range error.
interface poly_mod_sub_if #(
   parameter int unsigned IW = 8
) ();

   logic          in_valid;
   logic          in_ready;
   logic [11:0]   a_data;
   logic [11:0]   b_data;
   logic          out_valid;
   logic          out_ready;
   logic [11:0]   out_data;
   logic [IW-1:0] out_index;
   logic          out_last;
   logic          err;

   // Producer/consumer side: drives operands and downstream ready.
   modport master (
      output in_valid, a_data, b_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last, err
   );

   // Subtractor side.
   modport slave (
      input  in_valid, a_data, b_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last, err
   );

endinterface

// File: rtl/poly_mod_sub.sv
// Streaming coefficient-wise modular subtractor: out = (a - b) mod Q.
// Two-stage elastic pipeline (S1 raw difference, S2 modular fold) with a
// per-polynomial coefficient index travelling alongside the data.
// Optional macro POLY_MOD_SUB_CHECK_EN adds a sticky operand range error
// flag; without it err is tied to 0 and no comparators are built.
module poly_mod_sub #(
   parameter int unsigned Q  = 3329,  // modulus, must fit in 12 bits
   parameter int unsigned N  = 256,   // coefficients per polynomial
   parameter int unsigned IW = $clog2(N)
) (
   input logic          clk,
   input logic          rst,
   poly_mod_sub_if.slave bus
);

   localparam logic [11:0]   Q12     = 12'(Q);
   localparam logic [IW-1:0] LastIdx = IW'(N - 1);

   // Stage 1: 13-bit two's complement difference
   logic          s1_valid_q;
   logic [12:0]   s1_diff_q;
   logic [IW-1:0] s1_index_q;

   // Stage 2: folded result presented on the output
   logic          s2_valid_q;
   logic [11:0]   s2_data_q;
   logic [IW-1:0] s2_index_q;
   logic          s2_last_q;

   logic [IW-1:0] cnt_q;

   logic          s2_load;
   logic          s1_moves;
   logic          s1_load;
   logic          in_ready;
   logic          accept;
   logic [12:0]   diff_in;
   logic [11:0]   fold_sum;
   logic [11:0]   s2_data_d;

   // Handshake and datapath combinational logic; in_ready depends only on
   // state and out_ready, never on in_valid.
   always_comb begin
      s2_load   = !s2_valid_q || bus.out_ready;
      s1_moves  = s1_valid_q && s2_load;
      s1_load   = !s1_valid_q || s1_moves;
      in_ready  = !rst && s1_load;
      accept    = bus.in_valid && in_ready;
      diff_in   = {1'b0, bus.a_data} - {1'b0, bus.b_data};
      // Adding Q modulo 4096 is enough: only the low 12 bits are kept.
      fold_sum  = s1_diff_q[11:0] + Q12;
      s2_data_d = s1_diff_q[12] ? fold_sum : s1_diff_q[11:0];
   end

   // Stage 1 register: capture the raw difference and its index on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_diff_q  <= '0;
         s1_index_q <= '0;
      end else if (s1_load) begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_diff_q  <= diff_in;
            s1_index_q <= cnt_q;
         end
      end
   end

   // Stage 2 register: fold negative differences back into 0..Q-1
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_index_q <= '0;
         s2_last_q  <= 1'b0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q  <= s2_data_d;
            s2_index_q <= s1_index_q;
            s2_last_q  <= (s1_index_q == LastIdx);
         end
      end
   end

   // Coefficient index counter, wraps at the end of each polynomial
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
      end
   end

`ifdef POLY_MOD_SUB_CHECK_EN
   logic err_q;

   // Sticky flag for any accepted operand outside 0..Q-1
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept && ((bus.a_data >= Q12) || (bus.b_data >= Q12))) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_index = s2_index_q;
   assign bus.out_last  = s2_last_q;

endmodule

// File: tb/tb_poly_mod_sub.sv
// Self-checking bench for poly_mod_sub: scoreboard of expected results fed
// by the driver on each accepted pair, drained by an output monitor.
module tb_poly_mod_sub;

   localparam int Q = 3329;
   localparam int N = 256;

   typedef struct {
      int data;
      int idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   poly_mod_sub_if #(.IW(8)) bus ();

   poly_mod_sub #(
      .Q (Q),
      .N (N)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   exp_idx   = 0;
   int   n_sent    = 0;
   int   n_out     = 0;
   bit   hold_prev = 1'b0;
   int   prev_data = 0;
   int   prev_idx  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model(input int a, input int b);
      int d;
      d = a - b;
      if (d < 0) d = d + Q;
      return d & 'hFFF;
   endfunction

   // One clock of stimulus: drive at negedge, decide acceptance once settled.
   task automatic drive_cycle(input bit v, input int a, input int b, input bit rdy,
                              output bit acc);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.a_data    = 12'(a);
      bus.b_data    = 12'(b);
      bus.out_ready = rdy;
      #1;
      acc = v && bus.in_ready;
      if (acc) begin
         e.data = model(a, b);
         e.idx  = exp_idx;
         sb.push_back(e);
         exp_idx = (exp_idx + 1) % N;
         n_sent++;
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      bit acc;
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 0, rdy, acc);
   endtask

   task automatic send(input int a, input int b, input bit rdy, output int stalls);
      bit acc;
      acc    = 1'b0;
      stalls = 0;
      for (int i = 0; i < 50 && !acc; i++) begin
         drive_cycle(1'b1, a, b, rdy, acc);
         if (!acc) stalls++;
      end
      if (!acc) check_eq("send_timeout", 32'(acc), 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 1000 && sb.size() != 0; i++) idle(1, 1'b1);
      idle(2, 1'b1);
      check_eq("drain_empty", sb.size(), 0);
   endtask

   // Reset with in-flight content discarded; checks reset output state.
   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      n_sent        = n_sent - sb.size();
      sb.delete();
      exp_idx       = 0;
      @(negedge clk);
      #1;
      check_eq("rst_in_ready", bus.in_ready, 0);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_out_data", bus.out_data, 0);
      check_eq("rst_out_index", bus.out_index, 0);
      check_eq("rst_out_last", bus.out_last, 0);
      check_eq("rst_err", bus.err, 0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_in_ready", bus.in_ready, 1);
   endtask

   // Output monitor: stability under backpressure and scoreboard compare.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_data", bus.out_data, prev_data);
            check_eq("hold_index", bus.out_index, prev_idx);
         end
         if (bus.out_valid && bus.out_ready) begin
            check_eq("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check_eq("out_data", bus.out_data, e.data);
               check_eq("out_index", bus.out_index, e.idx);
               check_eq("out_last", bus.out_last, 32'(e.idx == N - 1));
               n_out++;
            end
         end
         hold_prev = bus.out_valid && !bus.out_ready;
         prev_data = int'(bus.out_data);
         prev_idx  = int'(bus.out_index);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int stalls;
      int total_stalls;
      int k;
      int accepts;
      int pa[$];
      int pb[$];

      bus.in_valid  = 1'b0;
      bus.a_data    = '0;
      bus.b_data    = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      do_reset();

      // Latency: accepted at t, visible at t+2
      drive_cycle(1'b1, 5, 3, 1'b1, acc);
      check_eq("lat_accept", acc, 1);
      idle(1, 1'b1);
      check_eq("lat_t1_valid", bus.out_valid, 0);
      idle(1, 1'b1);
      check_eq("lat_t2_valid", bus.out_valid, 1);
      check_eq("lat_t2_data", bus.out_data, 2);
      check_eq("lat_t2_index", bus.out_index, 0);
      drain();

      // Directed boundary pairs
      send(3, 5, 1'b1, stalls);
      send(0, 3328, 1'b1, stalls);
      send(3328, 0, 1'b1, stalls);
      send(1664, 1664, 1'b1, stalls);
      drain();

      // Full polynomial back-to-back plus restart of the next polynomial
      do_reset();
      total_stalls = 0;
      for (int i = 0; i < N + 3; i++) begin
         send($urandom_range(Q - 1), $urandom_range(Q - 1), 1'b1, stalls);
         total_stalls += stalls;
      end
      check_eq("throughput_stalls", total_stalls, 0);
      drain();

      // Backpressure from empty: only two pairs can be buffered
      pa.delete();
      pb.delete();
      for (int i = 0; i < 8; i++) begin
         pa.push_back(100 + i * 13);
         pb.push_back(i * 517);
      end
      k       = 0;
      accepts = 0;
      for (int c = 0; c < 6; c++) begin
         drive_cycle(1'b1, pa[k], pb[k], 1'b0, acc);
         if (acc) begin
            accepts++;
            k++;
         end
      end
      check_eq("bp_accepts", accepts, 2);
      check_eq("bp_in_ready", bus.in_ready, 0);
      check_eq("bp_out_valid", bus.out_valid, 1);
      while (k < 8) begin
         send(pa[k], pb[k], 1'b1, stalls);
         k++;
      end
      drain();

      // Mid-stream stall of three cycles
      k = 0;
      for (int c = 0; c < 100 && k < 20; c++) begin
         drive_cycle(1'b1, (k * 211) % Q, (k * 997) % Q, !(c >= 5 && c < 8), acc);
         if (c == 7) check_eq("stall_in_ready", bus.in_ready, 0);
         if (acc) k++;
      end
      drain();

      // Reset with two pairs in flight at index 10
      do_reset();
      for (int i = 0; i < 10; i++) send(i + 40, i, 1'b1, stalls);
      drain();
      send(11, 22, 1'b0, stalls);
      send(33, 44, 1'b0, stalls);
      idle(1, 1'b0);
      check_eq("inflight_valid", bus.out_valid, 1);
      check_eq("inflight_index", bus.out_index, 10);
      do_reset();
      send(7, 2, 1'b1, stalls);
      drain();

      // Range error flag
      check_eq("err_before", bus.err, 0);
      send(3329, 0, 1'b1, stalls);
      idle(1, 1'b1);
`ifdef POLY_MOD_SUB_CHECK_EN
      check_eq("err_set", bus.err, 1);
      idle(3, 1'b1);
      check_eq("err_sticky", bus.err, 1);
`else
      check_eq("err_tied", bus.err, 0);
      idle(3, 1'b1);
      check_eq("err_tied_later", bus.err, 0);
`endif
      drain();
      do_reset();

      check_eq("out_count", n_out, n_sent);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
